// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the two-channel select arbiter.
// Imported by mux_sel_arbiter.
package mux_sel_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT0,
      ARB_GRANT1
   } arb_state_t;

   // Reset value of sel; 1 makes the first tie go to channel 0.
   localparam logic SEL_RESET = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// A lone requester wins; a tie goes to the channel opposite 'last'.
module rr_pick2 (
   input  logic valid_0,
   input  logic valid_1,
   input  logic last,
   output logic any,
   output logic pick
);

   assign any  = valid_0 | valid_1;
   assign pick = (valid_0 && valid_1) ? ~last : valid_1;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-channel round-robin arbiter that drives the 2:1 mux select and forwards
// the granted channel's beats through a one-entry registered output stage.
module mux_sel_arbiter
   import mux_sel_pkg::*;
#(
   parameter int DATA_W    = 1,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din_0,
   input  logic              din_0_valid,
   output logic              din_0_ready,
   input  logic [DATA_W-1:0] din_1,
   input  logic              din_1_valid,
   output logic              din_1_ready,
   output logic              sel,
   output logic [DATA_W-1:0] mux_out,
   output logic              mux_out_valid,
   input  logic              mux_out_ready
);

   localparam int                CNT_W      = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_MAX - 1);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic [CNT_W-1:0]  burst_cnt;
   logic              accept;
   logic              pick_any;
   logic              pick;
   logic              grant_valid;
   logic [DATA_W-1:0] grant_data;
   logic              xfer;

   // Output register is free when empty or being drained this cycle.
   assign accept = !mux_out_valid || mux_out_ready;
   assign xfer   = grant_valid && accept;

   rr_pick2 u_pick (
      .valid_0 (din_0_valid),
      .valid_1 (din_1_valid),
      .last    (sel),
      .any     (pick_any),
      .pick    (pick)
   );

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt   = state;
      din_0_ready = 1'b0;
      din_1_ready = 1'b0;
      grant_valid = 1'b0;
      grant_data  = din_0;
      case (state)
         ARB_IDLE: begin
            if (pick_any) state_nxt = pick ? ARB_GRANT1 : ARB_GRANT0;
         end
         ARB_GRANT0: begin
            din_0_ready = accept;
            grant_valid = din_0_valid;
         end
         ARB_GRANT1: begin
            din_1_ready = accept;
            grant_valid = din_1_valid;
            grant_data  = din_1;
         end
         default: state_nxt = ARB_IDLE;
      endcase
      // Leave the grant when the requester lets go or the burst's last beat moves.
      if (state != ARB_IDLE && (!grant_valid || (xfer && burst_cnt == BURST_LAST)))
         state_nxt = ARB_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         sel       <= SEL_RESET;
         burst_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ARB_IDLE && pick_any) begin
            sel       <= pick;
            burst_cnt <= '0;
         end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end

   // A transfer coinciding with a drain replaces the beat in place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mux_out       <= '0;
         mux_out_valid <= 1'b0;
      end else if (xfer) begin
         mux_out       <= grant_data;
         mux_out_valid <= 1'b1;
      end else if (mux_out_ready) begin
         mux_out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Two-channel round-robin arbiter with valid/ready handshakes that sits directly upstream of the 2:1 select mux. It owns the select decision and drives `sel` as a registered output. It also forwards the winning channel's data through a one-entry registered output stage. Grants are held for bursts of up to `BURST_MAX` consecutive beats.

## Interface
- `DATA_W`, default 1: width of each data channel.
- `BURST_MAX`, default 4, legal range 1..15: maximum beats per grant before re-arbitration.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `din_0`  in  DATA_W  channel 0 data.
- `din_0_valid`  in  1  channel 0 has data.
- `din_0_ready`  out  1  channel 0 beat accepted this cycle when high with valid.
- `din_1`, `din_1_valid`, `din_1_ready`: as channel 0.
- `sel`  out  1  current or most recent grant (0 = channel 0); registered.
- `mux_out`  out  DATA_W  registered output data.
- `mux_out_valid`  out  1  `mux_out` holds a beat.
- `mux_out_ready`  in  1  downstream accepts the beat.

## Operation
- `accept = !mux_out_valid || mux_out_ready`: the output register can take a new beat.
- FSM states are `ARB_IDLE`, `ARB_GRANT0`, `ARB_GRANT1`.
- **In `ARB_IDLE`:**
  - Both ready outputs are 0. No transfer occurs.
  - If only one valid is high, go to that channel's grant state.
  - If both are high, grant channel `!sel` (round-robin).
  - If neither is high, stay in `ARB_IDLE`.
  - Arbitration ignores `accept`.
- **In `ARB_GRANTx`:**
  - `din_x_ready = accept`; the other channel's ready is 0.
  - A transfer occurs when `din_x_valid && accept`. On a transfer: `mux_out <= din_x`, `mux_out_valid <= 1`, `burst_cnt++`.
  - Go to `ARB_IDLE` when a transfer makes `burst_cnt == BURST_MAX`, or when `din_x_valid == 0`.
  - A stalled grant (valid high, `accept` low) holds the state and `burst_cnt`.
- **`sel`:**
  - 0 in `ARB_GRANT0`, 1 in `ARB_GRANT1`.
  - Holds its last value in `ARB_IDLE`.
- **`burst_cnt`:** width `$clog2(BURST_MAX+1)`; cleared on every entry to a grant state. It never wraps because the FSM exits at `BURST_MAX`.
- **`mux_out_valid`:** cleared when `mux_out_ready` is high and no transfer occurs that cycle. If a transfer and `mux_out_ready` coincide, valid stays 1 and data is replaced (pass-through).
- **`mux_out`:** holds its value while `mux_out_valid && !mux_out_ready`.

## Timing
- **Reset values:** state `ARB_IDLE`, `sel = 1`, `burst_cnt = 0`, `mux_out = 0`, `mux_out_valid = 0`, both ready outputs 0.
- `sel` resets to 1 so that the first tie is granted to channel 0.
- **Latency:** valid rising in `ARB_IDLE` gives a grant state next cycle. The first ready/transfer is in that cycle; `mux_out_valid` rises the cycle after.
- **Throughput:** one beat per cycle within a grant. Each re-arbitration costs exactly one bubble cycle (`ARB_IDLE`).
- **Reset mid-operation:** asserting `rst_n` low asynchronously clears all state; any held or in-flight beat is dropped.
- **Upstream rule:** data must be stable while valid is high and ready is low. A channel that drops valid while granted loses the grant.
- **Combinational paths:** the only one is `mux_out_ready` to `din_x_ready`. There is no valid-to-ready combinational path.

## Structure
- **Package `mux_sel_pkg`:** `typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT0, ARB_GRANT1}`, and `localparam` `SEL_RESET = 1'b1`.
- **Sub-module `rr_pick2`:** combinational round-robin picker. Inputs are `valid_0`, `valid_1`, `last`. Outputs are `any`, `pick`.
- The output register stage and the FSM live in `mux_sel_arbiter`.

## Test plan
All scenarios use `DATA_W = 8`, `BURST_MAX = 4`.

- **Reset:** hold `rst_n = 0` for 3 cycles, with `din_0_valid = 1` and `mux_out_ready = 1`.
  - Expect `sel = 1`, both ready outputs 0, `mux_out_valid = 0`, `mux_out = 8'h00`.
- **Single channel:** only channel 1 valid, data `8'hA0..8'hA5`, ready = 1.
  - Expect `sel = 1`, then beats A0–A3, one bubble, then A4–A5.
  - Expect `mux_out_valid` high one cycle after each transfer.
- **Contention:** both channels valid continuously (ch0 `8'h10..`, ch1 `8'h20..`), ready = 1.
  - Output sequence: 10, 11, 12, 13, bubble, 20, 21, 22, 23, bubble, 14, …
  - `sel` reads 0, 0, 0, 0, 0, 1, … during this sequence.
- **Backpressure:** in `ARB_GRANT0`, hold `mux_out_ready = 0` for 5 cycles with a beat held.
  - Expect `mux_out` stable, `din_0_ready = 0`, `burst_cnt` unchanged.
  - On release, expect no lost or duplicated beat.
- **Release and reset mid-burst:**
  - Channel 0 drops valid after 2 beats while channel 1 is valid: expect `ARB_IDLE` for one cycle, then `sel = 1`.
  - Pull `rst_n` low mid-burst: `mux_out_valid` drops in the same cycle (asynchronously) and `sel` returns to 1.
